// File: rtl/tone_sequencer.sv
// tone_sequencer: plays a fixed 8-entry note table as a square wave on the
// buzzer pin, with note and gap lengths counted in ticks from a divider.
// Ports: clk, rst (sync, active high), start, stop, tick (inputs);
//        audio, busy, note_idx[2:0], done (registered outputs).
module tone_sequencer #(
   parameter int NOTES = 8,
   parameter int DUR   = 2,
   parameter int GAP   = 1,
   parameter int LOOP  = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       tick,
   output logic       audio,
   output logic       busy,
   output logic [2:0] note_idx,
   output logic       done
);

   localparam int MAXD = (DUR > GAP) ? DUR : GAP;
   localparam int CW   = $clog2(MAXD + 1);

   localparam logic [CW-1:0] DUR_LAST = CW'(DUR - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'((GAP > 0) ? (GAP - 1) : 0);
   localparam logic [2:0]    IDX_LAST = 3'(NOTES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_NOTE,
      S_GAP
   } state_t;

   state_t        state_q;
   logic [2:0]    note_idx_q;
   logic [15:0]   tone_cnt_q;
   logic [CW-1:0] dur_cnt_q;
   logic          audio_q;
   logic          busy_q;
   logic          done_q;

   logic [15:0]   half;
   logic          note_end;
   logic          gap_end;
   logic          advance;

   // Half-periods in clk cycles; zero would mean a rest.
   always_comb begin
      half = 16'd0;
      unique case (note_idx_q)
         3'd0: half = 16'd22934;
         3'd1: half = 16'd20432;
         3'd2: half = 16'd18202;
         3'd3: half = 16'd17181;
         3'd4: half = 16'd15306;
         3'd5: half = 16'd13636;
         3'd6: half = 16'd12149;
         3'd7: half = 16'd11467;
      endcase
   end

   assign note_end = (state_q == S_NOTE) && tick
                     && (dur_cnt_q == DUR_LAST);
   assign gap_end  = (state_q == S_GAP) && tick
                     && (dur_cnt_q == GAP_LAST);
   // With no gap, the end of a note moves straight on.
   assign advance  = (note_end && (GAP == 0)) || gap_end;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         note_idx_q <= '0;
         tone_cnt_q <= '0;
         dur_cnt_q  <= '0;
         audio_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;

         unique case (state_q)
            S_IDLE: begin
               audio_q <= 1'b0;
               busy_q  <= 1'b0;
               if (start && !stop) begin
                  state_q    <= S_NOTE;
                  note_idx_q <= '0;
                  tone_cnt_q <= '0;
                  dur_cnt_q  <= '0;
                  busy_q     <= 1'b1;
               end
            end

            S_NOTE: begin
               if (half == 16'd0) begin
                  tone_cnt_q <= '0;
                  audio_q    <= 1'b0;
               end else if (tone_cnt_q == half - 16'd1) begin
                  tone_cnt_q <= '0;
                  audio_q    <= ~audio_q;
               end else begin
                  tone_cnt_q <= tone_cnt_q + 16'd1;
               end

               if (tick) begin
                  if (dur_cnt_q != DUR_LAST) begin
                     dur_cnt_q <= dur_cnt_q + CW'(1);
                  end else if (GAP > 0) begin
                     state_q   <= S_GAP;
                     dur_cnt_q <= '0;
                     audio_q   <= 1'b0;
                  end
               end
            end

            S_GAP: begin
               audio_q <= 1'b0;
               if (tick && (dur_cnt_q != GAP_LAST)) begin
                  dur_cnt_q <= dur_cnt_q + CW'(1);
               end
            end

            default: state_q <= S_IDLE;
         endcase

         // Overrides the per-state updates above.
         if (advance) begin
            tone_cnt_q <= '0;
            dur_cnt_q  <= '0;
            audio_q    <= 1'b0;
            if (note_idx_q != IDX_LAST) begin
               note_idx_q <= note_idx_q + 3'd1;
               state_q    <= S_NOTE;
            end else if (LOOP != 0) begin
               note_idx_q <= '0;
               state_q    <= S_NOTE;
            end else begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
         end

         // Abort beats tick and a natural end on the same edge.
         if (stop && (state_q != S_IDLE)) begin
            state_q    <= S_IDLE;
            note_idx_q <= '0;
            tone_cnt_q <= '0;
            dur_cnt_q  <= '0;
            audio_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
         end
      end
   end

   assign audio    = audio_q;
   assign busy     = busy_q;
   assign note_idx = note_idx_q;
   assign done     = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed steps with random tick spacing, checked
// every cycle against a tick-count model of the note schedule.
module tb_tone_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       stop;
   logic       tick;
   logic       a1, b1, d1;
   logic       a2, b2, d2;
   logic [2:0] i1, i2;

   tone_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .tick     (tick),
      .audio    (a1),
      .busy     (b1),
      .note_idx (i1),
      .done     (d1)
   );

   tone_sequencer #(
      .NOTES (2),
      .DUR   (1),
      .GAP   (0),
      .LOOP  (1)
   ) dut_loop (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .tick     (tick),
      .audio    (a2),
      .busy     (b2),
      .note_idx (i2),
      .done     (d2)
   );

   always #5 clk = ~clk;

   int HALF [8] = '{22934, 20432, 18202, 17181,
                    15306, 13636, 12149, 11467};

   int n_tests = 0;
   int n_fail  = 0;
   bit sel;
   int mN, mD, mG, mL;
   int cyc;
   bit m_busy, m_done, m_idx0;
   int m_cnt, m_entry;
   int done_seen;
   int t, gapc, ticks, t_done, max_idx;

   function automatic logic o_aud();
      return sel ? a2 : a1;
   endfunction

   function automatic logic o_busy();
      return sel ? b2 : b1;
   endfunction

   function automatic logic o_done();
      return sel ? d2 : d1;
   endfunction

   function automatic logic [2:0] o_idx();
      return sel ? i2 : i1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d, want %0d (cycle %0d)",
                tag, obs, exp, cyc);
      end
   endtask

   // The schedule is a count of accepted ticks: each note owns DUR+GAP
   // of them, the first DUR audible; audio phase is time since entry.
   task automatic model_edge(input logic st, input logic sp,
                             input logic tk);
      int p;
      p = mD + mG;
      if (rst) begin
         m_busy = 0;
         m_done = 0;
         m_idx0 = 1;
      end else if (!m_busy) begin
         m_done = 0;
         if (st && !sp) begin
            m_busy  = 1;
            m_cnt   = 0;
            m_entry = cyc;
         end
      end else if (sp) begin
         m_busy = 0;
         m_done = 0;
         m_idx0 = 1;
      end else begin
         m_done = 0;
         if (tk) begin
            m_cnt++;
            if (mL == 0 && m_cnt == mN * p) begin
               m_busy = 0;
               m_done = 1;
               m_idx0 = 0;
            end else if (m_cnt % p == 0) begin
               m_entry = cyc;
            end
         end
      end
   endtask

   task automatic check_model();
      int p, ei, ea;
      p  = mD + mG;
      ei = m_busy ? (m_cnt / p) % mN : 0;
      ea = 0;
      if (m_busy && (m_cnt % p) < mD)
         ea = ((cyc - m_entry) / HALF[ei]) % 2;
      chk("busy", o_busy(), m_busy);
      chk("done", o_done(), m_done);
      chk("audio", o_aud(), ea);
      if (m_busy || m_idx0)
         chk("note_idx", o_idx(), ei);
   endtask

   task automatic step(input logic st, input logic sp, input logic tk);
      start = st;
      stop  = sp;
      tick  = tk;
      @(posedge clk);
      cyc++;
      model_edge(st, sp, tk);
      #1;
      check_model();
      if (o_done() === 1'b1) done_seen++;
   endtask

   task automatic wait_audio(input logic lvl, input int maxc,
                             output int tm);
      tm = -1;
      for (int k = 0; k < maxc; k++) begin
         step(1'b0, 1'b0, 1'b0);
         if (o_aud() === lvl) begin
            tm = cyc - m_entry;
            break;
         end
      end
   endtask

   initial begin
      sel = 0;
      mN = 8; mD = 2; mG = 1; mL = 0;
      m_busy = 0; m_done = 0; m_idx0 = 1;
      m_cnt = 0; m_entry = 0; cyc = 0;
      done_seen = 0;
      rst = 1'b1; start = 1'b0; stop = 1'b0; tick = 1'b0;

      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);
      chk("rst_audio", o_aud(), 0);
      chk("rst_busy", o_busy(), 0);
      chk("rst_idx", o_idx(), 0);
      chk("rst_done", o_done(), 0);
      rst = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      chk("no_start_captured", o_busy(), 0);

      step(1'b1, 1'b0, 1'b0);
      chk("busy_after_start", o_busy(), 1);
      wait_audio(1'b1, 23000, t);
      chk("c4_rise", t, 22934);
      wait_audio(1'b0, 23000, t);
      chk("c4_fall", t, 45868);
      step(1'b0, 1'b1, 1'b0);
      chk("stop_idle", o_busy(), 0);

      step(1'b1, 1'b1, 1'b0);
      chk("start_stop_idle", o_busy(), 0);
      step(1'b0, 1'b0, 1'b1);
      chk("tick_in_idle", o_busy(), 0);

      done_seen = 0; max_idx = 0; ticks = 0; t_done = -1;
      step(1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 30 && t_done < 0; k++) begin
         gapc = $urandom_range(1, 20);
         for (int j = 0; j < gapc; j++) begin
            step(($urandom_range(0, 7) == 0)
                 || (j == 0 && o_idx() == 3'd2), 1'b0, 1'b0);
            if (int'(o_idx()) > max_idx) max_idx = int'(o_idx());
         end
         step(1'b0, 1'b0, 1'b1);
         ticks++;
         if (o_done() === 1'b1) t_done = ticks;
      end
      for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0);
      chk("ticks_to_done", t_done, 24);
      chk("done_pulses", done_seen, 1);
      chk("max_idx", max_idx, 7);
      chk("idle_audio", o_aud(), 0);

      step(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 9; k++) begin
         gapc = $urandom_range(0, 5);
         for (int j = 0; j < gapc; j++) step(1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b1);
      end
      step(1'b0, 1'b0, 1'b0);
      chk("pre_abort_idx", o_idx(), 3);
      chk("pre_abort_busy", o_busy(), 1);
      done_seen = 0;
      step(1'b0, 1'b1, 1'b1);
      chk("abort_busy", o_busy(), 0);
      chk("abort_idx", o_idx(), 0);
      chk("abort_audio", o_aud(), 0);
      chk("abort_done", o_done(), 0);
      step(1'b0, 1'b0, 1'b0);
      chk("abort_no_done", done_seen, 0);

      sel = 1;
      mN = 2; mD = 1; mG = 0; mL = 1;
      rst = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      done_seen = 0;
      step(1'b1, 1'b0, 1'b0);
      chk("loop_start_idx", o_idx(), 0);
      for (int k = 1; k <= 5; k++) begin
         gapc = $urandom_range(1, 20);
         for (int j = 0; j < gapc; j++) step(1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b1);
         chk("loop_idx", o_idx(), k % 2);
      end
      wait_audio(1'b1, 20500, t);
      chk("d4_rise", t, 20432);
      step(1'b0, 1'b0, 1'b1);
      chk("loop_wrap_idx", o_idx(), 0);
      chk("loop_busy", o_busy(), 1);
      chk("loop_no_done", done_seen, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Plays a fixed 8-note scale as a square-wave audio signal. It sits directly downstream of the tick divider.
- Consumes the divider's 1-cycle tick, for example every 100 ms at 12 MHz, as its note-timing base.
- Steps through an internal note table, holding each note for DUR ticks and inserting GAP ticks of silence between notes.
- Drives the buzzer pin. Optionally loops the sequence.

Parameters:
- NOTES, 8, number of table entries played (1..8), starting from index 0.
- DUR, 2, ticks each note sounds (>=1).
- GAP, 1, silent ticks after each note (>=0; 0 means no gap state).
- LOOP, 0, 1 restarts at index 0 after the last note; 0 returns to idle.

Ports:
- clk  in  1  system clock, 12 MHz.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin playback. Sampled only in IDLE; ignored otherwise.
- stop  in  1  abort playback. Returns to IDLE next cycle.
- tick  in  1  timing strobe from the divider. Each high cycle counts as one tick.
- audio  out  1  square-wave output to the buzzer. Registered.
- busy  out  1  high in NOTE or GAP. Registered.
- note_idx  out  3  index of the current table entry. Registered.
- done  out  1  1-cycle pulse when a non-looping sequence ends naturally.

Behaviour:
- Reset (rst high at a clk edge, overrides all other inputs): state=IDLE, audio=0, busy=0, note_idx=0, done=0, all counters=0.
- Note table, 16-bit half-periods in clk cycles:
  - 0: 22934 (C4)
  - 1: 20432 (D4)
  - 2: 18202 (E4)
  - 3: 17181 (F4)
  - 4: 15306 (G4)
  - 5: 13636 (A4)
  - 6: 12149 (B4)
  - 7: 11467 (C5)
  - A value of 0 is a rest: audio is held at 0.
- States: IDLE, NOTE, GAP.
- IDLE:
  - audio=0, busy=0.
  - start=1 at edge N moves to NOTE with note_idx=0, tone_cnt=0, dur_cnt=0, audio=0. busy=1 from N+1.
- NOTE:
  - tone_cnt increments every clk.
  - When tone_cnt == half-1: tone_cnt<=0 and audio toggles. The first audio rise is exactly `half` cycles after entering NOTE.
  - On tick: if dur_cnt == DUR-1, the note ends; otherwise dur_cnt++.
  - Note end with GAP>0: go to GAP, dur_cnt=0, audio=0.
  - Note end with GAP=0: advance directly (see Advance).
- GAP:
  - audio=0.
  - On tick: if dur_cnt == GAP-1, advance; otherwise dur_cnt++.
- Advance:
  - If note_idx < NOTES-1: note_idx++, enter NOTE with tone_cnt=0, dur_cnt=0, audio=0.
  - Else if LOOP=1: note_idx=0, enter NOTE.
  - Else: go to IDLE, busy=0, and done=1 for exactly one cycle, at the same edge busy falls.
- stop:
  - In NOTE or GAP, the next state is IDLE, audio=0, busy=0, note_idx=0. No done pulse.
  - stop and tick in the same cycle: stop wins.
  - start and stop together in IDLE: stay in IDLE.
- start while busy: ignored, with no restart and no effect on counters.
- tick in IDLE: ignored.
- A tick in the same cycle as entering NOTE or GAP is not counted. Counting starts the cycle after entry.
- dur_cnt width: $clog2(max(DUR,GAP)+1). tone_cnt width: 16 bits, no overflow possible.

Test Plan:
- Reset with default params: rst=1 for 3 cycles while start=1 -> audio=0, busy=0, note_idx=0, done=0; no start captured.
- Single note period: start=1 for 1 cycle, tick held low -> busy=1 next cycle; audio rises 22934 cycles after NOTE entry, falls 22934 cycles later, continues periodic.
- Full sequence, NOTES=8, DUR=2, GAP=1, LOOP=0, tick every 100000 cycles:
  - note_idx steps 0..7, with audio silent for 1 tick between notes.
  - After the 24th counted tick: busy falls and done=1 for exactly 1 cycle.
  - audio=0 thereafter.
- Loop, LOOP=1, NOTES=2, DUR=1, GAP=0 -> note_idx pattern 0,1,0,1 on successive ticks; done never asserts; audio half-period switches 22934<->20432.
- Abort: stop asserted mid-note (note_idx=3) in the same cycle as tick -> next cycle IDLE, audio=0, note_idx=0, busy=0, done=0.
- Start ignored while busy: start pulse during note 2 -> note_idx and dur_cnt sequence unchanged versus the reference run without the pulse.
